// File: rtl/uart_msg_arbiter.sv
// Three-way round-robin arbiter in front of a single UART message transmitter.
// A grant latches the winner's payload and owns the transmitter until done, reject or timeout.
module uart_msg_arbiter #(
  parameter logic [15:0] START_TIMEOUT = 16'd2000,
  parameter logic [3:0]  MAX_BYTES     = 4'd12
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [2:0]   req,
  input  logic [287:0] req_data,
  input  logic [11:0]  req_len,
  input  logic [8:0]   req_times,
  output logic [2:0]   ack,
  output logic [2:0]   err,
  output logic         busy,
  output logic [95:0]  TX_BYTE,
  output logic [3:0]   no_of_bytes,
  output logic [2:0]   transmit_count,
  output logic         TX_DATA_VALID,
  input  logic         O_TX_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t      state;
  logic [1:0]  rr;
  logic [1:0]  owner;
  logic [15:0] wait_cnt;
  logic [16:0] wait_cnt_next;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [2:0]  cand;
  logic [95:0] win_data;
  logic [3:0]  win_len;
  logic [2:0]  win_times;
  logic        len_ok;

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Search order is rr, rr+1, rr+2 wrapped modulo 3; the first active request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_found && req[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    win_data  = req_data[95:0];
    win_len   = req_len[3:0];
    win_times = req_times[2:0];
    case (win_idx)
      2'd1: begin
        win_data  = req_data[191:96];
        win_len   = req_len[7:4];
        win_times = req_times[5:3];
      end
      2'd2: begin
        win_data  = req_data[287:192];
        win_len   = req_len[11:8];
        win_times = req_times[8:6];
      end
      default: begin
        win_data  = req_data[95:0];
        win_len   = req_len[3:0];
        win_times = req_times[2:0];
      end
    endcase
  end

  assign len_ok        = (win_len != 4'd0) && (win_len <= MAX_BYTES);
  assign wait_cnt_next = {1'b0, wait_cnt} + 17'd1;

  // Rejected grants skip the transmitter but still pass through FINISH so rr advances uniformly.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      rr             <= 2'd0;
      owner          <= 2'd0;
      wait_cnt       <= 16'd0;
      TX_DATA_VALID  <= 1'b0;
      ack            <= 3'b000;
      err            <= 3'b000;
      busy           <= 1'b0;
      TX_BYTE        <= 96'd0;
      no_of_bytes    <= 4'd0;
      transmit_count <= 3'd0;
    end else begin
      ack <= 3'b000;
      err <= 3'b000;
      case (state)
        IDLE: begin
          if (win_found) begin
            owner          <= win_idx;
            TX_BYTE        <= win_data;
            no_of_bytes    <= win_len;
            transmit_count <= (win_times == 3'd0) ? 3'd1 : win_times;
            busy           <= 1'b1;
            if (len_ok) begin
              state         <= LAUNCH;
              TX_DATA_VALID <= 1'b1;
            end else begin
              state <= FINISH;
              err   <= one_hot(win_idx);
            end
          end
        end
        LAUNCH: begin
          state    <= WAIT_START;
          wait_cnt <= 16'd0;
        end
        WAIT_START: begin
          if (!O_TX_DONE) begin
            TX_DATA_VALID <= 1'b0;
            state         <= WAIT_DONE;
          end else if (wait_cnt_next >= {1'b0, START_TIMEOUT}) begin
            TX_DATA_VALID <= 1'b0;
            err           <= one_hot(owner);
            state         <= FINISH;
          end else begin
            wait_cnt <= wait_cnt_next[15:0];
          end
        end
        WAIT_DONE: begin
          if (O_TX_DONE) begin
            ack   <= one_hot(owner);
            state <= FINISH;
          end
        end
        FINISH: begin
          rr    <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          TX_DATA_VALID <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter with a simple transmitter model on O_TX_DONE.
// Outputs are sampled on the falling clock edge; all expectations are hand-derived.
module tb_uart_msg_arbiter;

  localparam logic [95:0] D0 = 96'h0A0B0C0D;
  localparam logic [95:0] D1 = 96'hCCBBAA;
  localparam logic [95:0] D2 = 96'h5566778899AA;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic [2:0]   req = 3'b000;
  logic [287:0] req_data = {D2, D1, D0};
  logic [11:0]  req_len = 12'd0;
  logic [8:0]   req_times = 9'd0;
  logic [2:0]   ack;
  logic [2:0]   err;
  logic         busy;
  logic [95:0]  TX_BYTE;
  logic [3:0]   no_of_bytes;
  logic [2:0]   transmit_count;
  logic         TX_DATA_VALID;
  logic         O_TX_DONE = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int ack_pulses = 0;
  int err_pulses = 0;
  int overlap = 0;
  int tx_timer = 0;
  logic tx_auto = 1'b1;

  uart_msg_arbiter #(
    .START_TIMEOUT(16'd10),
    .MAX_BYTES    (4'd12)
  ) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .req           (req),
    .req_data      (req_data),
    .req_len       (req_len),
    .req_times     (req_times),
    .ack           (ack),
    .err           (err),
    .busy          (busy),
    .TX_BYTE       (TX_BYTE),
    .no_of_bytes   (no_of_bytes),
    .transmit_count(transmit_count),
    .TX_DATA_VALID (TX_DATA_VALID),
    .O_TX_DONE     (O_TX_DONE)
  );

  always #10 CLOCK = ~CLOCK;

  // Transmitter: done drops 2 cycles after valid is seen and returns 40 cycles later.
  always @(negedge CLOCK) begin
    if (RESET || !tx_auto) begin
      O_TX_DONE = 1'b1;
      tx_timer  = 0;
    end else if (tx_timer == 0) begin
      if (TX_DATA_VALID && O_TX_DONE) tx_timer = 1;
    end else begin
      tx_timer++;
      if (tx_timer == 3) O_TX_DONE = 1'b0;
      else if (tx_timer == 43) begin
        O_TX_DONE = 1'b1;
        tx_timer  = 0;
      end
    end
  end

  always @(negedge CLOCK) begin
    ack_pulses += $countones(ack);
    err_pulses += $countones(err);
    if ((ack != 3'b000) && (err != 3'b000)) overlap++;
  end

  function automatic logic [95:0] dataOf(input int id);
    case (id)
      0:       return D0;
      1:       return D1;
      default: return D2;
    endcase
  endfunction

  function automatic logic [2:0] bitOf(input int id);
    return 3'b001 << id;
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [11:0] lens, input logic [8:0] times);
    req       = r;
    req_len   = lens;
    req_times = times;
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!TX_DATA_VALID && n < limit) begin
      @(negedge CLOCK);
      n++;
    end
  endtask

  task automatic waitAck(input int limit, output int n);
    n = 0;
    while (ack == 3'b000 && n < limit) begin
      @(negedge CLOCK);
      n++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 96'(TX_DATA_VALID), 96'd0);
    checkOutput({tag, "_busy"}, 96'(busy), 96'd0);
    checkOutput({tag, "_ack"}, 96'(ack), 96'd0);
    checkOutput({tag, "_err"}, 96'(err), 96'd0);
    checkOutput({tag, "_tx_byte"}, TX_BYTE, 96'd0);
    checkOutput({tag, "_no_of_bytes"}, 96'(no_of_bytes), 96'd0);
    checkOutput({tag, "_transmit_count"}, 96'(transmit_count), 96'd0);
  endtask

  initial begin
    int n;

    repeat (2) @(negedge CLOCK);
    checkAllZero("reset");
    RESET = 1'b0;

    // Single request from requester 1
    @(negedge CLOCK);
    applyStimulus(3'b010, {4'd6, 4'd3, 4'd4}, {3'd1, 3'd2, 3'd1});
    checkOutput("single_valid_before", 96'(TX_DATA_VALID), 96'd0);
    @(negedge CLOCK);
    checkOutput("single_valid_rise", 96'(TX_DATA_VALID), 96'd1);
    checkOutput("single_busy", 96'(busy), 96'd1);
    checkOutput("single_tx_byte", TX_BYTE, D1);
    checkOutput("single_no_of_bytes", 96'(no_of_bytes), 96'd3);
    checkOutput("single_transmit_count", 96'(transmit_count), 96'd2);
    repeat (2) @(negedge CLOCK);
    checkOutput("single_valid_held", 96'(TX_DATA_VALID), 96'd1);
    @(negedge CLOCK);
    checkOutput("single_valid_drop", 96'(TX_DATA_VALID), 96'd0);
    waitAck(100, n);
    checkOutput("single_ack_latency", 96'(n), 96'd40);
    checkOutput("single_ack", 96'(ack), 96'(3'b010));
    checkOutput("single_busy_in_finish", 96'(busy), 96'd1);
    checkOutput("single_tx_byte_stable", TX_BYTE, D1);
    req = 3'b000;
    @(negedge CLOCK);
    checkOutput("single_ack_pulse_end", 96'(ack), 96'd0);
    checkOutput("single_busy_fall", 96'(busy), 96'd0);

    // Fairness with all three requests held from reset
    RESET = 1'b1;
    applyStimulus(3'b111, {4'd6, 4'd3, 4'd4}, {3'd3, 3'd2, 3'd1});
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    for (int i = 0; i < 6; i++) begin
      waitValid(20, n);
      checkOutput("fair_gap", 96'(n), (i == 0) ? 96'd0 : 96'd2);
      checkOutput("fair_grant_data", TX_BYTE, dataOf(i % 3));
      waitAck(100, n);
      checkOutput("fair_ack", 96'(ack), 96'(bitOf(i % 3)));
      if (i == 5) req = 3'b000;
    end
    @(negedge CLOCK);

    // Illegal lengths on requester 0, then rr must favour requester 1
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    applyStimulus(3'b001, {4'd6, 4'd3, 4'd0}, {3'd1, 3'd0, 3'd1});
    @(negedge CLOCK);
    checkOutput("badlen0_err", 96'(err), 96'(3'b001));
    checkOutput("badlen0_valid", 96'(TX_DATA_VALID), 96'd0);
    checkOutput("badlen0_busy", 96'(busy), 96'd1);
    req = 3'b000;
    @(negedge CLOCK);
    checkOutput("badlen0_err_end", 96'(err), 96'd0);
    checkOutput("badlen0_idle", 96'(busy), 96'd0);
    applyStimulus(3'b001, {4'd6, 4'd3, 4'd13}, {3'd1, 3'd0, 3'd1});
    @(negedge CLOCK);
    checkOutput("badlen13_err", 96'(err), 96'(3'b001));
    checkOutput("badlen13_valid", 96'(TX_DATA_VALID), 96'd0);
    req = 3'b000;
    @(negedge CLOCK);
    applyStimulus(3'b011, {4'd6, 4'd3, 4'd5}, {3'd1, 3'd0, 3'd1});
    @(negedge CLOCK);
    checkOutput("rr_after_reject_valid", 96'(TX_DATA_VALID), 96'd1);
    checkOutput("rr_after_reject_winner", TX_BYTE, D1);
    checkOutput("times_zero_as_one", 96'(transmit_count), 96'd1);
    waitAck(100, n);
    checkOutput("rr_after_reject_ack", 96'(ack), 96'(3'b010));
    req = 3'b000;
    @(negedge CLOCK);

    // Start timeout with the transmitter never acknowledging
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    tx_auto = 1'b0;
    @(negedge CLOCK);
    applyStimulus(3'b011, {4'd6, 4'd3, 4'd4}, {3'd1, 3'd2, 3'd1});
    @(negedge CLOCK);
    checkOutput("timeout_valid_rise", 96'(TX_DATA_VALID), 96'd1);
    checkOutput("timeout_winner", TX_BYTE, D0);
    n = 0;
    while (TX_DATA_VALID && n < 50) begin
      n++;
      @(negedge CLOCK);
    end
    checkOutput("timeout_valid_cycles", 96'(n), 96'd11);
    checkOutput("timeout_err", 96'(err), 96'(3'b001));
    checkOutput("timeout_no_ack", 96'(ack), 96'd0);
    applyStimulus(3'b010, {4'd6, 4'd3, 4'd4}, {3'd1, 3'd2, 3'd1});
    tx_auto = 1'b1;
    waitValid(20, n);
    checkOutput("timeout_next_gap", 96'(n), 96'd2);
    checkOutput("timeout_next_winner", TX_BYTE, D1);
    waitAck(100, n);
    checkOutput("timeout_next_ack", 96'(ack), 96'(3'b010));
    req = 3'b000;
    @(negedge CLOCK);

    // Reset while waiting for done, then requester 2 is granted again
    applyStimulus(3'b100, {4'd6, 4'd3, 4'd4}, {3'd1, 3'd2, 3'd1});
    @(negedge CLOCK);
    checkOutput("midreset_valid_rise", 96'(TX_DATA_VALID), 96'd1);
    checkOutput("midreset_winner", TX_BYTE, D2);
    repeat (3) @(negedge CLOCK);
    checkOutput("midreset_in_wait_done", 96'(TX_DATA_VALID), 96'd0);
    checkOutput("midreset_busy", 96'(busy), 96'd1);
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge CLOCK);
    checkOutput("midreset_no_ack", 96'(ack), 96'd0);
    checkOutput("midreset_no_err", 96'(err), 96'd0);
    RESET = 1'b0;
    @(negedge CLOCK);
    checkOutput("midreset_regrant_valid", 96'(TX_DATA_VALID), 96'd1);
    checkOutput("midreset_regrant_winner", TX_BYTE, D2);
    waitAck(100, n);
    checkOutput("midreset_regrant_ack", 96'(ack), 96'(3'b100));
    req = 3'b000;
    @(negedge CLOCK);

    checkOutput("ack_pulse_total", 96'(ack_pulses), 96'd10);
    checkOutput("err_pulse_total", 96'(err_pulses), 96'd3);
    checkOutput("ack_err_overlap", 96'(overlap), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_msg_arbiter.md
UART_MSG_ARBITER -- requirements
Module: uart_msg_arbiter

Interface
REQ-001 Parameter: START_TIMEOUT, default 16'd2000, max cycles to wait for O_TX_DONE to fall after launch.
REQ-002 Parameter: MAX_BYTES, default 4'd12, largest legal message length in bytes.
REQ-003 CLOCK  input  1  50 MHz system clock; all state on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 req  input  3  per-requester request level; req[i] is held high until ack[i] or err[i].
REQ-006 req_data  input  288  payload; bits [96*i+95:96*i] belong to requester i, with byte 0 in the LSBs.
REQ-007 req_len  input  12  byte count; bits [4*i+3:4*i] belong to requester i.
REQ-008 req_times  input  9  repeat count; bits [3*i+2:3*i] belong to requester i.
REQ-009 ack  output  3  one-cycle pulse on bit i when requester i's message has completed.
REQ-010 err  output  3  one-cycle pulse on bit i when requester i's message is rejected or aborted.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 TX_BYTE  output  96  payload to the transmitter.
REQ-013 no_of_bytes  output  4  length to the transmitter.
REQ-014 transmit_count  output  3  repeat count to the transmitter.
REQ-015 TX_DATA_VALID  output  1  launch strobe to the transmitter.
REQ-016 O_TX_DONE  input  1  transmitter done flag; high when idle, low while sending.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE, FINISH; encoding is free.
REQ-018 IDLE with req==0: remain in IDLE; TX_DATA_VALID=0.
REQ-019 IDLE with any req bit high, winner selection:
- Round-robin search starting at pointer rr.
- Winner w is the first i in order rr, rr+1, rr+2 (mod 3) with req[i]=1.
REQ-020 IDLE with a winner, on the same edge:
- Latch w and w's req_data/req_len/req_times slices into TX_BYTE/no_of_bytes/transmit_count.
- Go to LAUNCH.
REQ-021 Length check on the winner:
- If req_len slice is 0 or greater than MAX_BYTES, do not launch.
- Pulse err[w] on the next cycle, update rr, and return to IDLE.
REQ-022 Repeat-count check on the winner: a req_times slice of 0 is sent as 1.
REQ-023 LAUNCH: TX_DATA_VALID=1 and go to WAIT_START. TX_DATA_VALID first rises exactly one cycle after the winning req is sampled in IDLE.
REQ-024 WAIT_START: hold TX_DATA_VALID=1 until O_TX_DONE is sampled low, then drop TX_DATA_VALID and go to WAIT_DONE.
REQ-025 WAIT_START timeout: a 16-bit counter starts at 0 on entry and increments each cycle. At count==START_TIMEOUT, drop TX_DATA_VALID, pulse err[w], and go to FINISH.
REQ-026 WAIT_DONE:
- Remain while O_TX_DONE=0; TX_DATA_VALID=0.
- On O_TX_DONE sampled high, pulse ack[w] and go to FINISH.
- No timeout in this state.
REQ-027 FINISH:
- Set rr=(w+1) mod 3.
- Go to IDLE; TX_DATA_VALID=0.
- Minimum gap between consecutive launches is therefore 2 cycles.
REQ-028 TX_BYTE, no_of_bytes and transmit_count stay stable from LAUNCH until the next grant; they change only in IDLE on a grant.
REQ-029 Requests arriving or dropping while busy=1 are ignored; they are evaluated only in IDLE.
REQ-030 A req withdrawn before it is sampled in IDLE is never served and never acked.
REQ-031 Exactly one ack or err pulse is produced per grant; ack and err are never high together.
REQ-032 The rr pointer advances after every grant, including rejected and timed-out grants.

Reset
REQ-033 RESET=1 asynchronously forces:
- FSM to IDLE, rr=0, timeout counter=0.
- TX_DATA_VALID=0, ack=0, err=0, busy=0.
- TX_BYTE=0, no_of_bytes=0, transmit_count=0.
REQ-034 RESET asserted mid-transfer:
- The in-flight message produces no ack or err.
- After release, pending requests are re-arbitrated from rr=0.
REQ-035 Release: the first grant may occur on the first rising edge after RESET falls.

Verification
REQ-036 Single request: req=3'b010, len=3, data=96'h0000..00_CC_BB_AA, transmitter model drops done 2 cycles after valid and raises it 40 cycles later.
- TX_DATA_VALID rises 1 cycle after req is sampled.
- no_of_bytes=3, TX_BYTE=96'h..CCBBAA.
- ack=3'b010 pulses for 1 cycle; busy falls 2 cycles after O_TX_DONE rises.
REQ-037 Fairness: req=3'b111 held continuously from reset. Grant order is 0, 1, 2, 0, 1, 2, with one ack per grant.
REQ-038 Bad length: req[0] with len=0, then req[0] with len=13. err[0] pulses each time, TX_DATA_VALID never rises, and rr advances to 1.
REQ-039 Timeout: O_TX_DONE tied high, START_TIMEOUT=10.
- TX_DATA_VALID stays high for exactly 10 cycles of WAIT_START, then drops.
- err[w] pulses; the next requester is served afterwards.
REQ-040 Reset in WAIT_DONE: assert RESET 5 cycles into the transfer. All outputs go to 0 immediately and no ack is produced. With req=3'b100 still held, requester 2 is re-granted after release.
